// File: rtl/frame_loader.sv
// frame_loader: assembles a W-bit word stream into an n-bit frame, launches an
// LDPC decode, bounds the wait with a watchdog and hands back a result with
// running frame/failure counters.
module frame_loader #(
    parameter int unsigned n            = 2048,
    parameter int unsigned W            = 32,
    parameter int unsigned log2words    = 6,
    parameter int unsigned log2max_iter = 5,
    parameter int unsigned TIMEOUT      = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W-1:0]            in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [n-1:0]            frame,
    output logic                    dec_start,
    input  logic                    dec_done,
    input  logic                    dec_success,
    input  logic [log2max_iter-1:0] dec_iterations,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    result_success,
    output logic [log2max_iter-1:0] result_iterations,
    output logic                    result_timeout,
    output logic [15:0]             frame_count,
    output logic [15:0]             fail_count
);

    localparam int unsigned Words = n / W;
    localparam int unsigned IdxW  = $clog2(n);
    localparam logic [log2words-1:0] LastWord = log2words'(Words - 1);
    localparam logic [15:0]          WdogLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StFill, StBusy, StResult} state_e;

    state_e                  state_q, state_d;
    logic [log2words-1:0]    word_cnt_q;
    logic [15:0]             wdog_q;
    logic [n-1:0]            frame_q;
    logic                    res_success_q;
    logic [log2max_iter-1:0] res_iter_q;
    logic                    res_timeout_q;
    logic [15:0]             frame_cnt_q;
    logic [15:0]             fail_cnt_q;
    logic                    accept;
    logic                    done_ok;
    logic                    expired;
    logic                    handshake;
    logic [IdxW-1:0]         wr_base;

    assign wr_base = IdxW'(word_cnt_q) * IdxW'(W);

    // Next-state and control decode from the registered state.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        dec_start    = 1'b0;
        result_valid = 1'b0;
        accept       = 1'b0;
        done_ok      = 1'b0;
        expired      = 1'b0;
        handshake    = 1'b0;
        unique case (state_q)
            StFill: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (accept && (word_cnt_q == LastWord)) state_d = StBusy;
            end
            StBusy: begin
                // Watchdog at zero marks the launch cycle; dec_done there is stale.
                dec_start = (wdog_q == '0);
                done_ok   = dec_done && (wdog_q != '0);
                expired   = (wdog_q == WdogLast);
                if (done_ok || expired) state_d = StResult;
            end
            StResult: begin
                result_valid = 1'b1;
                handshake    = result_ready;
                if (result_ready) state_d = StFill;
            end
            default: state_d = StFill;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StFill;
        else     state_q <= state_d;
    end

    // Word counter and frame assembly; frame is only written while filling.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
            frame_q    <= '0;
        end else if (accept) begin
            frame_q[wr_base +: W] <= in_data;
            word_cnt_q <= (word_cnt_q == LastWord) ? '0 : word_cnt_q + log2words'(1);
        end
    end

    // Watchdog runs only in BUSY and restarts from zero on each entry.
    always_ff @(posedge clk) begin
        if (rst)                   wdog_q <= '0;
        else if (state_q == StBusy) wdog_q <= wdog_q + 16'd1;
        else                       wdog_q <= '0;
    end

    // Result capture; a real completion takes priority over watchdog expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_success_q <= 1'b0;
            res_iter_q    <= '0;
            res_timeout_q <= 1'b0;
        end else if (done_ok) begin
            res_success_q <= dec_success;
            res_iter_q    <= dec_iterations;
            res_timeout_q <= 1'b0;
        end else if (expired) begin
            res_success_q <= 1'b0;
            res_iter_q    <= '1;
            res_timeout_q <= 1'b1;
        end
    end

    // Frame counter wraps; failure counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            fail_cnt_q  <= '0;
        end else if (handshake) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (!res_success_q && (fail_cnt_q != 16'hFFFF)) fail_cnt_q <= fail_cnt_q + 16'd1;
        end
    end

    assign frame             = frame_q;
    assign result_success    = res_success_q;
    assign result_iterations = res_iter_q;
    assign result_timeout    = res_timeout_q;
    assign frame_count       = frame_cnt_q;
    assign fail_count        = fail_cnt_q;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: drives frames, models the decoder, and checks
// results against a scoreboard queue of expected outcomes.
module tb_frame_loader;

    localparam int unsigned NW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2047:0] frame;
    logic          dec_start;
    logic          dec_done = 1'b0;
    logic          dec_success = 1'b0;
    logic [4:0]    dec_iterations = '0;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic          result_success;
    logic [4:0]    result_iterations;
    logic          result_timeout;
    logic [15:0]   frame_count;
    logic [15:0]   fail_count;

    frame_loader #(
        .n(2048), .W(32), .log2words(6), .log2max_iter(5), .TIMEOUT(4096)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .frame(frame), .dec_start(dec_start),
        .dec_done(dec_done), .dec_success(dec_success), .dec_iterations(dec_iterations),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_success(result_success), .result_iterations(result_iterations),
        .result_timeout(result_timeout),
        .frame_count(frame_count), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       success;
        logic [4:0] iterations;
        logic       timeout;
    } res_t;

    res_t        exp_q[$];
    logic [31:0] exp_frame [NW];
    int n_tests = 0;
    int n_fail = 0;
    int start_pulses = 0;
    int accepts = 0;
    int ready_cycles = 0;
    int exp_frames = 0;
    int exp_fails = 0;

    // Monitor sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (dec_start) start_pulses++;
        if (in_valid && in_ready) accepts++;
        if (in_ready) ready_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag);
        logic [10:0] b;
        for (int k = 0; k < NW; k++) begin
            b = 11'(k * 32);
            check($sformatf("%s_w%0d", tag, k), 64'(frame[b +: 32]), 64'(exp_frame[k]));
        end
    endtask

    // Sends count words (k or random), optionally with idle gaps; if keep is set,
    // in_valid stays high with junk data afterwards.
    task automatic send_words(input int count, input bit gaps, input bit rnd, input bit keep);
        logic [31:0] w;
        int guard;
        for (int k = 0; k < count; k++) begin
            w = rnd ? 32'($urandom) : 32'(k);
            exp_frame[k] = w;
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            in_valid = 1'b1;
            in_data  = w;
            guard = 0;
            while (!in_ready && guard < 100) begin
                tick();
                guard++;
            end
            if (guard >= 100) check("in_ready_wait", 64'(in_ready), 64'd1);
            tick();
        end
        if (keep) begin
            in_valid = 1'b1;
            in_data  = 32'hDEADBEEF;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic expect_result(input string tag, input int exp_wait, input int hold);
        int   waited;
        res_t e;
        waited = 0;
        while (!result_valid && waited < 5000) begin
            tick();
            waited++;
        end
        check({tag, "_wait"}, 64'(waited), 64'(exp_wait));
        check({tag, "_qsize"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = '0;
        for (int h = 0; h <= hold; h++) begin
            check({tag, "_valid"}, 64'(result_valid), 64'd1);
            check({tag, "_success"}, 64'(result_success), 64'(e.success));
            check({tag, "_iter"}, 64'(result_iterations), 64'(e.iterations));
            check({tag, "_timeout"}, 64'(result_timeout), 64'(e.timeout));
            if (h < hold) tick();
        end
        exp_frames++;
        if (!e.success) exp_fails++;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_rv_clr"}, 64'(result_valid), 64'd0);
        check({tag, "_frames"}, 64'(frame_count), 64'(exp_frames));
        check({tag, "_fails"}, 64'(fail_count), 64'(exp_fails));
    endtask

    // Decoder model: raises dec_done after t cycles from now.
    task automatic decode(input string tag, input int t, input logic s, input logic [4:0] it,
                          input int hold);
        repeat (t) tick();
        dec_done       = 1'b1;
        dec_success    = s;
        dec_iterations = it;
        exp_q.push_back(res_t'{success: s, iterations: it, timeout: 1'b0});
        tick();
        dec_done       = 1'b0;
        dec_success    = 1'b0;
        dec_iterations = '0;
        expect_result(tag, 0, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_rvalid", 64'(result_valid), 64'd0);
        check("rst_start", 64'(dec_start), 64'd0);
        check("rst_frames", 64'(frame_count), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_frame", 64'(|frame), 64'd0);

        // Frame 1: contiguous words k, decode after 50 cycles.
        ready_cycles = 0;
        start_pulses = 0;
        send_words(NW, 1'b0, 1'b0, 1'b0);
        check("f1_start", 64'(dec_start), 64'd1);
        check("f1_busy_ready", 64'(in_ready), 64'd0);
        check_frame("f1");
        decode("f1", 50, 1'b1, 5'd7, 0);
        check("f1_ready_cycles", 64'(ready_cycles), 64'd64);
        check("f1_pulses", 64'(start_pulses), 64'd1);

        // Frame 2: random gaps and data, stale dec_done, in_valid held in BUSY/RESULT.
        accepts = 0;
        send_words(NW, 1'b1, 1'b1, 1'b1);
        check("f2_start", 64'(dec_start), 64'd1);
        check_frame("f2");
        dec_done       = 1'b1;
        dec_success    = 1'b1;
        dec_iterations = 5'd9;
        tick();
        dec_done = 1'b0;
        check("f2_stale", 64'(result_valid), 64'd0);
        decode("f2", 19, 1'b1, 5'd12, 10);
        in_valid = 1'b0;
        check("f2_accepts", 64'(accepts), 64'd64);
        check_frame("f2_held");

        // Frame 3: decoder never answers.
        send_words(NW, 1'b0, 1'b1, 1'b0);
        check("f3_start", 64'(dec_start), 64'd1);
        check_frame("f3");
        exp_q.push_back(res_t'{success: 1'b0, iterations: 5'h1f, timeout: 1'b1});
        expect_result("f3", 4096, 3);

        // Frame 4: dec_done in the watchdog's final cycle wins.
        send_words(NW, 1'b0, 1'b1, 1'b0);
        check_frame("f4");
        decode("f4", 4095, 1'b1, 5'd3, 0);

        // dec_done during FILL is ignored.
        dec_done    = 1'b1;
        dec_success = 1'b1;
        repeat (3) begin
            tick();
            check("fill_done_rv", 64'(result_valid), 64'd0);
            check("fill_done_ir", 64'(in_ready), 64'd1);
        end
        dec_done    = 1'b0;
        dec_success = 1'b0;

        // Reset after word 30, then a full frame.
        start_pulses = 0;
        send_words(31, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        exp_frames = 0;
        exp_fails  = 0;
        check("rst_mid_frames", 64'(frame_count), 64'd0);
        check("rst_mid_fails", 64'(fail_count), 64'd0);
        check("rst_mid_frame", 64'(|frame), 64'd0);
        check("rst_mid_iter", 64'(result_iterations), 64'd0);
        check("rst_mid_succ", 64'(result_success), 64'd0);
        check("rst_mid_rv", 64'(result_valid), 64'd0);
        check("rst_mid_in_ready1", 64'(in_ready), 64'd1);
        send_words(NW, 1'b1, 1'b1, 1'b0);
        check("f5_start", 64'(dec_start), 64'd1);
        check_frame("f5");
        decode("f5", 5, 1'b0, 5'd17, 2);
        check("f5_pulses", 64'(start_pulses), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
